// File: rtl/sevenseg_scan.sv
// Time-multiplexed 7-segment driver: prescaled digit scan with dead time, active-low outputs.
// Define SEVENSEG_SCAN_LZB_EN to add leading-zero blanking; port list is the same either way.
module sevenseg_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int DEAD_CYC   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    output logic                    a,
    output logic                    b,
    output logic                    c,
    output logic                    d,
    output logic                    e,
    output logic                    f,
    output logic                    g,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PRESC_DEAD = PW'(DEAD_CYC);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc_reg;
    logic [IW-1:0]           idx_reg;
    logic [4*NUM_DIGITS-1:0] value_reg;
    logic [NUM_DIGITS-1:0]   dp_reg;
    logic [NUM_DIGITS-1:0]   blank_reg;
    logic [6:0]              seg_reg;
    logic                    dp_out_reg;
    logic [NUM_DIGITS-1:0]   an_reg;

    logic [3:0]              nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   dark;
    logic [6:0]              seg_next;
    logic                    dp_next;
    logic [NUM_DIGITS-1:0]   an_next;
    logic                    show;

    // Lit-segment pattern, bit 6 = a ... bit 0 = g.
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] lit;
        case (n)
            4'h0: lit = 7'b1111110;
            4'h1: lit = 7'b0110000;
            4'h2: lit = 7'b1101101;
            4'h3: lit = 7'b1111001;
            4'h4: lit = 7'b0110011;
            4'h5: lit = 7'b1011011;
            4'h6: lit = 7'b1011111;
            4'h7: lit = 7'b1110000;
            4'h8: lit = 7'b1111111;
            4'h9: lit = 7'b1111011;
            4'hA: lit = 7'b1110111;
            4'hB: lit = 7'b0011111;
            4'hC: lit = 7'b1001110;
            4'hD: lit = 7'b0111101;
            4'hE: lit = 7'b1001111;
            default: lit = 7'b1000111;
        endcase
        return lit;
    endfunction

`ifdef SEVENSEG_SCAN_LZB_EN
    // lz[k]: nibbles k..top are all zero and none of them requests a decimal point
    logic [NUM_DIGITS:1] lz;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nib[gi] = value_reg[4*gi +: 4];
`ifdef SEVENSEG_SCAN_LZB_EN
            if (gi == 0) begin : g_keep
                assign dark[gi] = blank_reg[gi];
            end else begin : g_lzb
                if (gi == NUM_DIGITS - 1) begin : g_top
                    assign lz[gi] = (nib[gi] == 4'h0) && !dp_reg[gi];
                end else begin : g_mid
                    assign lz[gi] = lz[gi+1] && (nib[gi] == 4'h0) && !dp_reg[gi];
                end
                assign dark[gi] = blank_reg[gi] | lz[gi];
            end
`else
            assign dark[gi] = blank_reg[gi];
`endif
        end
    endgenerate

    always_comb begin
        show     = (presc_reg >= PRESC_DEAD) && !dark[idx_reg];
        an_next  = '1;
        seg_next = '1;
        dp_next  = 1'b1;
        if (show) begin
            an_next[idx_reg] = 1'b0;
            seg_next         = ~decode(nib[idx_reg]);
            dp_next          = ~dp_reg[idx_reg];
        end
    end

    // Outputs are a registered image of the pre-edge scan state and shadow contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg  <= '0;
            idx_reg    <= '0;
            value_reg  <= '0;
            dp_reg     <= '0;
            blank_reg  <= '1;
            seg_reg    <= '1;
            dp_out_reg <= 1'b1;
            an_reg     <= '1;
        end else begin
            if (presc_reg == PRESC_LAST) begin
                presc_reg <= '0;
                idx_reg   <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
            end else begin
                presc_reg <= presc_reg + 1'b1;
            end
            if (load) begin
                value_reg <= value;
                dp_reg    <= dp_in;
                blank_reg <= blank;
            end
            seg_reg    <= seg_next;
            dp_out_reg <= dp_next;
            an_reg     <= an_next;
        end
    end

    assign {a, b, c, d, e, f, g} = seg_reg;
    assign dp = dp_out_reg;
    assign an = an_reg;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan: fixed vectors, multi-cycle corner sequences and a random run vs. an arithmetic model.
module tb_sevenseg_scan;
    localparam int N = 4;
    localparam int S = 8;
    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank = '0;
    logic        a, b, c, d, e, f, g, dp;
    logic [3:0]  an;

    int checks = 0;
    int failures = 0;

    // model state: k = rising edges since reset release, plus shadow copies
    int          k;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic [3:0]  m_blank;

    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  dpi;
        logic [3:0]  blk;
        logic [1:0]  slot;
        logic [11:0] exp;
    } vec_t;
    vec_t vecs [12];

    string lit_tab [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                            "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    always #5 clk = ~clk;

    sevenseg_scan #(.NUM_DIGITS(N), .SCAN_DIV(S), .DEAD_CYC(D)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in), .blank(blank),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp), .an(an)
    );

    function automatic logic [6:0] lit_bits(input int nib);
        logic [6:0] r = '0;
        string s = lit_tab[nib];
        for (int i = 0; i < s.len(); i++) r[6 - (int'(s[i]) - 97)] = 1'b1;
        return r;
    endfunction

    function automatic logic digit_dark(input int dig);
        logic sup = 1'b0;
`ifdef SEVENSEG_SCAN_LZB_EN
        if (dig > 0) begin
            sup = 1'b1;
            for (int j = dig; j < N; j++)
                if (m_val[4*j +: 4] != 4'h0 || m_dp[j]) sup = 1'b0;
        end
`endif
        return m_blank[dig] | sup;
    endfunction

    function automatic logic [11:0] model_out();
        int presc = k % S;
        int idx = (k / S) % N;
        logic [3:0] an_e;
        if (presc < D || digit_dark(idx)) return '1;
        an_e = ~(4'b0001 << idx);
        return {an_e, ~lit_bits(int'(m_val[4*idx +: 4])), ~m_dp[idx]};
    endfunction

    function automatic logic [11:0] dut_out();
        return {an, a, b, c, d, e, f, g, dp};
    endfunction

    task automatic model_reset();
        k = 0;
        m_val = '0;
        m_dp = '0;
        m_blank = '1;
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s k=%0d: got an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
                     name, k, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    task automatic check_onehot();
        checks++;
        if ($isunknown(an) || $countones(~an) > 1) begin
            failures++;
            $display("FAIL an_at_most_one_low: got an=%b, required at most one 0 bit", an);
        end
    endtask

    task automatic tick();
        logic [11:0] exp;
        @(posedge clk);
        if (rst) begin
            exp = '1;
            model_reset();
        end else begin
            exp = model_out();
            if (load) begin
                m_val = value;
                m_dp = dp_in;
                m_blank = blank;
            end
            k++;
        end
        #1;
        check("scan", dut_out(), exp);
        check_onehot();
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 10000 && k < target; i++) tick();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check("reset", dut_out(), '1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_now(input logic [15:0] v, input logic [3:0] p, input logic [3:0] bl);
        value = v;
        dp_in = p;
        blank = bl;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        // {value, dp_in, blank, slot, {an, abcdefg, dp}} sampled at the first enabled cycle of the slot
        vecs[0]  = '{16'h1234, 4'b0000, 4'b0000, 2'd0, 12'b1110_1001100_1};
        vecs[1]  = '{16'h1234, 4'b0000, 4'b0000, 2'd3, 12'b0111_1001111_1};
        vecs[2]  = '{16'hABCD, 4'b0100, 4'b0000, 2'd2, 12'b1011_1100000_0};
        vecs[3]  = '{16'hABCD, 4'b0100, 4'b0000, 2'd0, 12'b1110_1000010_1};
        vecs[4]  = '{16'hABCD, 4'b0100, 4'b0000, 2'd3, 12'b0111_0001000_1};
        vecs[5]  = '{16'hABCD, 4'b0100, 4'b0000, 2'd1, 12'b1101_0110001_1};
        vecs[6]  = '{16'h1234, 4'b0000, 4'b0010, 2'd1, 12'b1111_1111111_1};
        vecs[8]  = '{16'h0050, 4'b0000, 4'b0000, 2'd1, 12'b1101_0100100_1};
        vecs[10] = '{16'h0050, 4'b0000, 4'b0000, 2'd0, 12'b1110_0000001_1};
        vecs[11] = '{16'h0000, 4'b0100, 4'b0000, 2'd2, 12'b1011_0000001_0};
`ifdef SEVENSEG_SCAN_LZB_EN
        vecs[7]  = '{16'h0050, 4'b0000, 4'b0000, 2'd3, 12'b1111_1111111_1};
        vecs[9]  = '{16'h0050, 4'b0000, 4'b0000, 2'd2, 12'b1111_1111111_1};
`else
        vecs[7]  = '{16'h0050, 4'b0000, 4'b0000, 2'd3, 12'b0111_0000001_1};
        vecs[9]  = '{16'h0050, 4'b0000, 4'b0000, 2'd2, 12'b1011_0000001_1};
`endif

        model_reset();
        #2 rst = 1'b1;
        #1;
        check("reset_state", dut_out(), '1);
        check_onehot();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            pulse_reset();
            load_now(vecs[i].val, vecs[i].dpi, vecs[i].blk);
            run_to(int'(vecs[i].slot) * S + D + 1);
            check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
        end

        // load on the edge that wraps digit 1 -> 2: digit 2 shows the new nibble (8) immediately
        pulse_reset();
        load_now(16'h1234, 4'b0000, 4'b0000);
        run_to(2 * S - 1);
        load_now(16'h9876, 4'b0000, 4'b0000);
        run_to(2 * S + D + 1);
        check("load_on_wrap", dut_out(), 12'b1011_0000000_1);

        // reset in the middle of digit 2's slot
        pulse_reset();
        load_now(16'h1234, 4'b0000, 4'b0000);
        run_to(2 * S + 4);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rst_mid_slot", dut_out(), '1);
        #1 rst = 1'b0;
        load_now(16'h5678, 4'b0000, 4'b0000);
        run_to(D);
        check("dead_after_rst", dut_out(), '1);
        run_to(D + 1);
        check("first_digit_after_rst", dut_out(), 12'b1110_0000000_1);

        // random loads and occasional asynchronous resets
        pulse_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                #1;
                model_reset();
                check("rand_async_reset", dut_out(), '1);
                #1 rst = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) begin
                value = 16'($urandom) >> $urandom_range(0, 15);
                dp_in = 4'($urandom) & 4'($urandom);
                blank = 4'($urandom) & 4'($urandom) & 4'($urandom);
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            tick();
        end
        load = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
